instr_fetch_unit: RTL and testbench

Instruction fetch stage feeding the processor's decode/control path. Holds the PC and issues in-order word fetches to a variable-latency instruction memory over a request/grant/response handshake. Buffers returned words with their PCs in a small prefetch FIFO and presents them to decode on a valid/ready interface. Supports redirects (branch/jump/trap) that flush the buffer and discard in-flight responses.

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues in-order word fetches over a
// req/gnt/rvalid handshake and buffers returned words with their PCs in a
// small prefetch FIFO that feeds decode on a valid/ready interface.
// Redirects flush the buffer and turn all in-flight responses into discards.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW+1:0] DEPTH_L = (CW+2)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [31:0]   mem_data [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];

   logic [CW+1:0] total;
   logic [31:0]   redir_aligned;
   logic          fire;
   logic          resp_drop;
   logic          resp_keep;
   logic          rv_any;
   logic          push;
   logic          pop;

   // Every word that is buffered, in flight or awaiting discard holds a
   // credit; a new request may only go out while a credit is free.
   assign total         = {2'b00, count} + {2'b00, outstanding} + {2'b00, discard};
   assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;

   assign imem_req  = !reset && !redirect && (total < DEPTH_L);
   assign imem_addr = fetch_pc;
   assign fire      = imem_req && imem_gnt;

   // Responses belong to stale requests first (discard), then to live ones.
   assign resp_drop = imem_rvalid && (discard != '0);
   assign resp_keep = imem_rvalid && (discard == '0) && (outstanding != '0);
   assign rv_any    = imem_rvalid && ((discard != '0) || (outstanding != '0));

   assign push = resp_keep && !redirect;
   assign pop  = instr_valid && instr_ready && !redirect;

   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? mem_data[rptr] : 32'h0;
   assign instr_pc    = instr_valid ? mem_pc[rptr]   : 32'h0;

   // Fetch PC advances on each accepted request; response PC on each kept word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= redir_aligned;
         resp_pc  <= redir_aligned;
      end else begin
         if (fire) fetch_pc <= fetch_pc + 32'd4;
         if (push) resp_pc  <= resp_pc + 32'd4;
      end
   end

   // In-flight bookkeeping; a redirect converts all outstanding into discards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         discard     <= '0;
      end else if (redirect) begin
         outstanding <= '0;
         discard     <= discard + outstanding - {{(CW-1){1'b0}}, rv_any};
      end else begin
         outstanding <= outstanding + {{(CW-1){1'b0}}, fire}
                                    - {{(CW-1){1'b0}}, resp_keep};
         discard     <= discard - {{(CW-1){1'b0}}, resp_drop};
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer outright.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else if (redirect) begin
         count <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else begin
         count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // FIFO storage holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wptr] <= imem_rdata;
         mem_pc[wptr]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a randomized memory with in-order,
// variable-latency responses, plus a queue-based reference model of the
// instruction stream that decode should see.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: words buffered for decode, and requests the memory
   // still owes a response for (stale ones belong to a flushed stream).
   logic [31:0] q_pc[$];
   logic [31:0] q_dat[$];
   logic [31:0] p_addr[$];
   bit          p_stale[$];
   int          p_cyc[$];
   logic [31:0] m_fetch;
   int          cyc = 0;
   int          p_gnt, p_rv, p_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic do_reset();
      reset       = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      #1;
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_imem_req",    32'(imem_req),    32'h0);
      check("rst_imem_addr",   imem_addr,        RESET_PC);
      check("rst_instr",       instr,            32'h0);
      check("rst_instr_pc",    instr_pc,         32'h0);
      q_pc.delete();  q_dat.delete();
      p_addr.delete(); p_stale.delete(); p_cyc.delete();
      m_fetch = RESET_PC;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock cycle: drive inputs at the falling edge, compare outputs,
   // then advance the reference model by what the rising edge will do.
   task automatic step(input bit do_redir, input logic [31:0] rpc);
      bit          exp_req, fire, rv, pop, stale;
      logic [31:0] a;
      redirect    = do_redir;
      redirect_pc = rpc;
      imem_gnt    = ($urandom_range(99) < p_gnt);
      instr_ready = ($urandom_range(99) < p_rdy);
      rv = (p_addr.size() > 0) && (p_cyc[0] < cyc) && ($urandom_range(99) < p_rv);
      imem_rvalid = rv;
      imem_rdata  = rv ? word_at(p_addr[0]) : $urandom();
      #1;
      exp_req = !do_redir && ((p_addr.size() + q_pc.size()) < DEPTH);
      check("imem_req",    32'(imem_req),    32'(exp_req));
      check("imem_addr",   imem_addr,        m_fetch);
      check("instr_valid", 32'(instr_valid), 32'(q_pc.size() > 0));
      check("instr",       instr,    (q_pc.size() > 0) ? q_dat[0] : 32'h0);
      check("instr_pc",    instr_pc, (q_pc.size() > 0) ? q_pc[0]  : 32'h0);

      fire = exp_req && imem_gnt;
      pop  = (q_pc.size() > 0) && instr_ready;
      if (rv) begin
         a     = p_addr.pop_front();
         stale = p_stale.pop_front();
         void'(p_cyc.pop_front());
         if (!stale && !do_redir) begin
            q_pc.push_back(a);
            q_dat.push_back(word_at(a));
         end
      end
      if (do_redir) begin
         q_pc.delete();
         q_dat.delete();
         foreach (p_stale[i]) p_stale[i] = 1'b1;
         m_fetch = {rpc[31:2], 2'b00};
      end else begin
         if (pop) begin
            void'(q_pc.pop_front());
            void'(q_dat.pop_front());
         end
         if (fire) begin
            p_addr.push_back(m_fetch);
            p_stale.push_back(1'b0);
            p_cyc.push_back(cyc);
            m_fetch = m_fetch + 32'd4;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      p_gnt = 100; p_rv = 100; p_rdy = 100;
      @(negedge clk);
      do_reset();

      // Free-running stream
      repeat (30) step(1'b0, 32'h0);

      // Decode stalls long enough to fill the buffer, then resumes
      p_rdy = 0;
      repeat (10) step(1'b0, 32'h0);
      p_rdy = 100;
      repeat (10) step(1'b0, 32'h0);

      // Memory withholds grant for three cycles
      p_gnt = 0;
      repeat (3) step(1'b0, 32'h0);
      p_gnt = 100;
      repeat (6) step(1'b0, 32'h0);

      // Two requests in flight, then redirect to an unaligned target
      p_rv = 0;
      repeat (3) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0103);
      p_rv = 100;
      repeat (10) step(1'b0, 32'h0);

      // Address wrap at the top of memory
      step(1'b1, 32'hFFFF_FFF8);
      repeat (12) step(1'b0, 32'h0);

      // Back-to-back redirects
      p_rv = 50;
      repeat (2) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_4000);
      step(1'b1, 32'h0000_8002);
      repeat (12) step(1'b0, 32'h0);

      // Random traffic with occasional redirects
      p_gnt = 60; p_rv = 50; p_rdy = 60;
      repeat (3000) step($urandom_range(99) < 5, $urandom());

      // Reset while the buffer is full
      p_gnt = 100; p_rv = 100; p_rdy = 0;
      repeat (8) step(1'b0, 32'h0);
      check("full_before_reset", 32'(instr_valid), 32'h1);
      do_reset();
      p_rdy = 100;
      repeat (20) step(1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
